// File: rtl/ula_datapath.sv
// ula_datapath: 8x8 register file feeding an ALU through a source-B mux.
// Optional build macro REG0_ZERO_EN: register 0 reads as zero and ignores writes.
module ula_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] constante,
    input  logic              select_src,
    input  logic [2:0]        ULAControl,
    output logic [DATA_W-1:0] ULAResult,
    output logic              CarryOut,
    output logic              Flag_z
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic [DATA_W-1:0] rd1SrcA, rd2, SrcB;
    logic [DATA_W:0]   add_s, sub_s;
    logic              wr_ok;

`ifdef REG0_ZERO_EN
    assign wr_ok   = we3 && wa3 != '0;
    assign rd1SrcA = ra1 == '0 ? '0 : regs[ra1];
    assign rd2     = ra2 == '0 ? '0 : regs[ra2];
`else
    assign wr_ok   = we3;
    assign rd1SrcA = regs[ra1];
    assign rd2     = regs[ra2];
`endif

    assign SrcB   = select_src ? constante : rd2;
    assign Flag_z = ULAResult == '0;

    // Register file: async clear wins over any write, otherwise one write per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            regs <= '{default: '0};
        else if (wr_ok)
            regs[wa3] <= wd3;
    end

    // ALU: subtraction is A + ~B + 1 so its carry doubles as "no borrow"
    always_comb begin
        add_s     = {1'b0, rd1SrcA} + {1'b0, SrcB};
        sub_s     = {1'b0, rd1SrcA} + {1'b0, ~SrcB} + (DATA_W+1)'(1);
        ULAResult = '0;
        CarryOut  = 1'b0;
        case (ULAControl)
            3'b000: {CarryOut, ULAResult} = add_s;
            3'b001: {CarryOut, ULAResult} = sub_s;
            3'b010: ULAResult = rd1SrcA & SrcB;
            3'b011: ULAResult = rd1SrcA | SrcB;
            3'b101: ULAResult = DATA_W'(rd1SrcA < SrcB);
            default: ULAResult = '0;
        endcase
    end
endmodule

// File: tb/tb_ula_datapath.sv
// tb_ula_datapath: scoreboard bench, directed vectors plus a short random run.
module tb_ula_datapath;
    logic       clk = 0, reset = 1, we3 = 0, select_src = 0;
    logic [2:0] wa3 = 0, ra1 = 0, ra2 = 0, ULAControl = 0;
    logic [7:0] wd3 = 0, constante = 0;
    logic [7:0] ULAResult;
    logic       CarryOut, Flag_z;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        string      nm;
    } exp_t;

    exp_t q[$];
    event ev;
    int   ntest = 0, nfail = 0;
    logic [7:0] mdl [8];

    ula_datapath dut (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .constante(constante), .select_src(select_src),
        .ULAControl(ULAControl), .ULAResult(ULAResult), .CarryOut(CarryOut), .Flag_z(Flag_z)
    );

    always #5 clk = ~clk;

    // Monitor: samples 1 ns after each presented operation and compares against the queue head
    initial forever begin
        exp_t e;
        @(ev);
        #1;
        if (q.size() == 0) begin
            nfail++;
            $display("FAIL monitor: output presented with empty scoreboard");
        end else begin
            e = q.pop_front();
            ntest++;
            if (ULAResult !== e.r || CarryOut !== e.c || Flag_z !== e.z) begin
                nfail++;
                $display("FAIL %s: got r=%02h c=%b z=%b, want r=%02h c=%b z=%b",
                         e.nm, ULAResult, CarryOut, Flag_z, e.r, e.c, e.z);
            end
        end
    end

    task automatic chk(input string nm, input logic [2:0] a1, input logic [2:0] a2,
                       input logic sel, input logic [7:0] cst, input logic [2:0] op,
                       input logic [7:0] er, input logic ec, input logic ez);
        exp_t e;
        ra1 = a1; ra2 = a2; select_src = sel; constante = cst; ULAControl = op;
        e.r = er; e.c = ec; e.z = ez; e.nm = nm;
        q.push_back(e);
        -> ev;
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we3 = 1; wa3 = a; wd3 = d;
        @(posedge clk);
        #1;
        we3 = 0;
    endtask

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                  output logic [7:0] r, output logic c);
        int s;
        r = 0; c = 0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = s[7:0]; c = s > 255; end
            3'd1: begin s = int'(a) - int'(b); r = s[7:0]; c = a >= b; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (a < b) ? 8'd1 : 8'd0;
            default: r = 0;
        endcase
    endfunction

    initial begin
        logic [7:0] a, b, r;
        logic       c;
        logic [2:0] ops [5];
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        #2;
        chk("reset_hold", 1, 1, 0, 0, 3'b000, 8'h00, 0, 1);
        #10;
        reset = 0;
        // Async reset pulse without a clock edge
        wr(1, 8'h05);
        #1 reset = 1;
        #1 reset = 0;
        chk("reset_pulse", 1, 1, 0, 0, 3'b000, 8'h00, 0, 1);
        // Register-register ops
        wr(1, 8'h05);
        wr(2, 8'h03);
        chk("add_rr", 1, 2, 0, 0, 3'b000, 8'h08, 0, 0);
        chk("sub_rr", 1, 2, 0, 0, 3'b001, 8'h02, 1, 0);
        chk("and_rr", 1, 2, 0, 0, 3'b010, 8'h01, 0, 0);
        chk("or_rr",  1, 2, 0, 0, 3'b011, 8'h07, 0, 0);
        chk("slt_rr", 1, 2, 0, 0, 3'b101, 8'h00, 0, 1);
        chk("slt_rr_t", 2, 1, 0, 0, 3'b101, 8'h01, 0, 0);
        // No write-through before the edge
        @(negedge clk);
        we3 = 1; wa3 = 1; wd3 = 8'h77;
        chk("no_bypass", 1, 2, 0, 0, 3'b000, 8'h08, 0, 0);
        @(posedge clk);
        #1 we3 = 0;
        chk("post_write", 1, 2, 0, 0, 3'b000, 8'h7A, 0, 0);
        // Constant path
        wr(1, 8'hF0);
        chk("add_const", 1, 0, 1, 8'h20, 3'b000, 8'h10, 1, 0);
        chk("slt_const_f", 1, 0, 1, 8'h20, 3'b101, 8'h00, 0, 1);
        chk("slt_const_t", 1, 0, 1, 8'hF1, 3'b101, 8'h01, 0, 0);
        // Wrap-around
        wr(1, 8'hFF);
        chk("add_wrap", 1, 0, 1, 8'h01, 3'b000, 8'h00, 1, 1);
        wr(1, 8'h00);
        chk("sub_borrow", 1, 0, 1, 8'h01, 3'b001, 8'hFF, 0, 0);
        // Zero / unused opcodes
        wr(1, 8'h3C);
        wr(2, 8'h3C);
        chk("sub_zero", 1, 2, 0, 0, 3'b001, 8'h00, 1, 1);
        chk("op110", 1, 2, 0, 0, 3'b110, 8'h00, 0, 1);
        chk("op100", 1, 2, 0, 0, 3'b100, 8'h00, 0, 1);
        chk("op111", 1, 2, 0, 0, 3'b111, 8'h00, 0, 1);
        // Reset held across a write edge
        @(negedge clk);
        reset = 1; we3 = 1; wa3 = 2; wd3 = 8'h99;
        @(posedge clk);
        #1;
        chk("reset_vs_write", 2, 2, 0, 0, 3'b000, 8'h00, 0, 1);
        reset = 0; we3 = 0;
        chk("after_reset", 2, 1, 0, 0, 3'b011, 8'h00, 0, 1);
        // Register 0
        wr(0, 8'h55);
`ifdef REG0_ZERO_EN
        chk("reg0", 0, 0, 1, 8'h00, 3'b011, 8'h00, 0, 1);
`else
        chk("reg0", 0, 0, 1, 8'h00, 3'b011, 8'h55, 0, 0);
`endif
        // Random regression against a reference register file
        @(negedge clk);
        reset = 1;
        #1 reset = 0;
        for (int i = 0; i < 8; i++) mdl[i] = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            we3 = 1'($urandom);
            wa3 = 3'($urandom);
            wd3 = 8'($urandom);
            ra1 = 3'($urandom);
            ra2 = 3'($urandom);
            select_src = 1'($urandom);
            constante = 8'($urandom);
            ULAControl = ops[i % 5];
`ifdef REG0_ZERO_EN
            a = ra1 == 0 ? 8'h00 : mdl[ra1];
            b = select_src ? constante : (ra2 == 0 ? 8'h00 : mdl[ra2]);
`else
            a = mdl[ra1];
            b = select_src ? constante : mdl[ra2];
`endif
            model(a, b, ULAControl, r, c);
            chk($sformatf("rand%0d", i), ra1, ra2, select_src, constante, ULAControl, r, c, r == 0);
            @(posedge clk);
            if (we3) mdl[wa3] = wd3;
            #1 we3 = 0;
        end
        #10;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d expected results never checked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
